// File: rtl/reg_file_sb.sv
// -----------------------------------------------------------------------------
// reg_file_sb
//   Multi-read, dual-write register file with a per-register scoreboard
//   (busy bit).
//   - Register 0 is hard-wired to zero and is never busy.
//   - Reads are combinational.
//   - Writes commit on the rising edge of clk. When both write ports target
//     the same address, write port 1 wins.
//   - A committed write clears the busy bit of its target register.
//   - A reserve sets the busy bit of its target. If a reserve and a write hit
//     the same register in one cycle, the busy bit stays set, because the new
//     producer wins.
//   - A flush clears every busy bit and overrides a same-cycle reserve.
//
// Optional feature (macro REG_FILE_SB_BYPASS_EN):
//   When defined, write data is forwarded to the read ports in the same cycle.
//   Write port 1 has precedence over write port 0. A forwarded read reports
//   rbusy = 0.
//   When undefined, reads return only the stored value.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   ra            NRD read addresses; port k is at [k*AW +: AW]
//   rd            NRD read data words; port k is at [k*XLEN +: XLEN]
//   rbusy         busy bit of the register addressed by each read port
//   we0/wa0/wd0   write port 0: enable, address, data
//   we1/wa1/wd1   write port 1: enable, address, data (has priority)
//   rsv_en        reserve request; marks rsv_addr busy
//   rsv_addr      address to reserve
//   flush         synchronous clear of all busy bits
//   rsv_conflict  one-cycle registered pulse; a reserve hit a busy register
// -----------------------------------------------------------------------------
module reg_file_sb #(
    parameter  int XLEN = 32,
    parameter  int NREG = 32,
    parameter  int NRD  = 2,
    localparam int AW   = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NRD*AW-1:0]    ra,
    output logic [NRD*XLEN-1:0]  rd,
    output logic [NRD-1:0]       rbusy,
    input  logic                 we0,
    input  logic                 we1,
    input  logic [AW-1:0]        wa0,
    input  logic [AW-1:0]        wa1,
    input  logic [XLEN-1:0]      wd0,
    input  logic [XLEN-1:0]      wd1,
    input  logic                 rsv_en,
    input  logic [AW-1:0]        rsv_addr,
    input  logic                 flush,
    output logic                 rsv_conflict
);

    logic [XLEN-1:0] r_regs [NREG];
    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_nxt;
    logic            r_rsv_conflict;
    logic            w_rsv_nz;
    logic            w_rsv_wr;
    logic            w_conflict_nxt;

    // Register 0 is constant zero and never busy.
    assign r_regs[0]     = {XLEN{1'b0}};
    assign w_busy_nxt[0] = 1'b0;

    genvar g;
    generate
        for (g = 1; g < NREG; g++) begin : g_reg
            logic w_wr0_hit;
            logic w_wr1_hit;
            logic w_rsv_hit;

            assign w_wr0_hit = we0 && (wa0 == AW'(g));
            assign w_wr1_hit = we1 && (wa1 == AW'(g));
            assign w_rsv_hit = rsv_en && (rsv_addr == AW'(g));

            // Busy bit priority: flush beats reserve, and reserve beats the
            // clearing effect of a write.
            assign w_busy_nxt[g] = flush     ? 1'b0 :
                                   w_rsv_hit ? 1'b1 :
                                   (w_wr0_hit || w_wr1_hit) ? 1'b0 : r_busy[g];

            // Storage update; write port 1 overrides port 0 on the same address.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_regs[g] <= {XLEN{1'b0}};
                end else if (w_wr1_hit) begin
                    r_regs[g] <= wd1;
                end else if (w_wr0_hit) begin
                    r_regs[g] <= wd0;
                end else begin
                    r_regs[g] <= r_regs[g];
                end
            end
        end
    endgenerate

    // Conflict: the reserve targets a register that is still busy after this
    // cycle's writes and flush are taken into account.
    assign w_rsv_nz       = rsv_en && (rsv_addr != {AW{1'b0}});
    assign w_rsv_wr       = (we0 && (wa0 == rsv_addr)) || (we1 && (wa1 == rsv_addr));
    assign w_conflict_nxt = w_rsv_nz && r_busy[rsv_addr] && !w_rsv_wr && !flush;

    // Scoreboard state and the registered conflict pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy         <= {NREG{1'b0}};
            r_rsv_conflict <= 1'b0;
        end else begin
            r_busy         <= w_busy_nxt;
            r_rsv_conflict <= w_conflict_nxt;
        end
    end

    assign rsv_conflict = r_rsv_conflict;

    genvar p;
    generate
        for (p = 0; p < NRD; p++) begin : g_rd
            logic [AW-1:0] w_ra;
            assign w_ra = ra[p*AW +: AW];
`ifdef REG_FILE_SB_BYPASS_EN
            logic w_fwd0;
            logic w_fwd1;
            assign w_fwd1 = we1 && (wa1 == w_ra) && (w_ra != {AW{1'b0}});
            assign w_fwd0 = we0 && (wa0 == w_ra) && (w_ra != {AW{1'b0}});
            assign rd[p*XLEN +: XLEN] = w_fwd1 ? wd1 :
                                        w_fwd0 ? wd0 : r_regs[w_ra];
            assign rbusy[p] = (w_fwd0 || w_fwd1) ? 1'b0 : r_busy[w_ra];
`else
            assign rd[p*XLEN +: XLEN] = r_regs[w_ra];
            assign rbusy[p]           = r_busy[w_ra];
`endif
        end
    endgenerate

endmodule

// File: tb/tb_reg_file_sb.sv
// -----------------------------------------------------------------------------
// tb_reg_file_sb
//   Directed bench for reg_file_sb. It instantiates two copies:
//   - u_dut uses the default parameters.
//   - u_dut_b uses NREG=16, XLEN=64, NRD=3.
//   All expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_reg_file_sb;

    logic        clk;
    logic        rst;

    // Default-parameter instance: AW=5, XLEN=32, NRD=2.
    logic [9:0]  ra;
    logic [63:0] rd;
    logic [1:0]  rbusy;
    logic        we0, we1;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic        flush;
    logic        rsv_conflict;

    // Wide instance: AW=4, XLEN=64, NRD=3.
    logic [11:0]  b_ra;
    logic [191:0] b_rd;
    logic [2:0]   b_rbusy;
    logic         b_we0, b_we1;
    logic [3:0]   b_wa0, b_wa1;
    logic [63:0]  b_wd0, b_wd1;
    logic         b_rsv_en;
    logic [3:0]   b_rsv_addr;
    logic         b_flush;
    logic         b_rsv_conflict;

    int n_checks;
    int n_fail;

    reg_file_sb u_dut (
        .clk(clk), .rst(rst), .ra(ra), .rd(rd), .rbusy(rbusy),
        .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush),
        .rsv_conflict(rsv_conflict)
    );

    reg_file_sb #(.XLEN(64), .NREG(16), .NRD(3)) u_dut_b (
        .clk(clk), .rst(rst), .ra(b_ra), .rd(b_rd), .rbusy(b_rbusy),
        .we0(b_we0), .we1(b_we1), .wa0(b_wa0), .wa1(b_wa1),
        .wd0(b_wd0), .wd1(b_wd1),
        .rsv_en(b_rsv_en), .rsv_addr(b_rsv_addr), .flush(b_flush),
        .rsv_conflict(b_rsv_conflict)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [63:0] act,
                             input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we0 = 1'b0; we1 = 1'b0; wa0 = 5'd0; wa1 = 5'd0;
        wd0 = 32'd0; wd1 = 32'd0;
        rsv_en = 1'b0; rsv_addr = 5'd0; flush = 1'b0;
        b_we0 = 1'b0; b_we1 = 1'b0; b_wa0 = 4'd0; b_wa1 = 4'd0;
        b_wd0 = 64'd0; b_wd1 = 64'd0;
        b_rsv_en = 1'b0; b_rsv_addr = 4'd0; b_flush = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        idle();
        ra   = 10'd0;
        b_ra = 12'd0;
        rst  = 1'b1;
        #23;

        // Reset state.
        ra = {5'd2, 5'd5};
        #1;
        check_val("reset_rd",    64'(rd), 64'h0);
        check_val("reset_rbusy", 64'(rbusy), 64'h0);
        check_val("reset_conf",  64'(rsv_conflict), 64'h0);
        rst = 1'b0;
        step();

        // Write reg5, then reserve it.
        we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF;
        step();
        idle();
        rsv_en = 1'b1; rsv_addr = 5'd5;
        step();
        idle();
        ra = {5'd0, 5'd5};
        #1;
        check_val("reg5_write", 64'(rd[31:0]), 64'hDEADBEEF);
        check_val("reg5_busy",  64'(rbusy[0]), 64'h1);

        // Mid-run async reset; the effect must be visible with no clock edge.
        #1;
        rst = 1'b1;
        #1;
        check_val("midrst_rd",    64'(rd[31:0]), 64'h0);
        check_val("midrst_rbusy", 64'(rbusy[0]), 64'h0);
        #2;
        rst = 1'b0;
        step();

        // x0: writes and reserves to address 0 are ignored.
        we0 = 1'b1; wa0 = 5'd0; wd0 = 32'h1234;
        step();
        idle();
        rsv_en = 1'b1; rsv_addr = 5'd0;
        step();
        rsv_en = 1'b1; rsv_addr = 5'd0;
        step();
        idle();
        ra = {5'd0, 5'd0};
        #1;
        check_val("x0_rd",    64'(rd), 64'h0);
        check_val("x0_rbusy", 64'(rbusy), 64'h0);
        check_val("x0_conf",  64'(rsv_conflict), 64'h0);

        // Collision: port 1 wins.
        we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h11;
        we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h22;
        step();
        idle();
        ra = {5'd0, 5'd7};
        #1;
        check_val("collision", 64'(rd[31:0]), 64'h22);

        // Two writes to different addresses both commit; the ports read
        // independently.
        we0 = 1'b1; wa0 = 5'd1; wd0 = 32'hAAAA0001;
        we1 = 1'b1; wa1 = 5'd2; wd1 = 32'hBBBB0002;
        step();
        idle();
        ra = {5'd2, 5'd1};
        #1;
        check_val("dual_wr", 64'(rd), 64'hBBBB0002_AAAA0001);

        // Scoreboard sequence.
        ra = {5'd0, 5'd3};
        rsv_en = 1'b1; rsv_addr = 5'd3;
        step();
        check_val("sb_busy",  64'(rbusy[0]), 64'h1);
        check_val("sb_conf0", 64'(rsv_conflict), 64'h0);
        step();                                   // second reserve of reg3
        check_val("sb_conf1", 64'(rsv_conflict), 64'h1);
        idle();
        step();
        check_val("sb_conf_pulse", 64'(rsv_conflict), 64'h0);
        we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h33;
        rsv_en = 1'b1; rsv_addr = 5'd3;
        step();
        idle();
        #1;
        check_val("sb_wr_rsv_busy", 64'(rbusy[0]), 64'h1);
        check_val("sb_wr_rsv_conf", 64'(rsv_conflict), 64'h0);
        check_val("sb_wr_data",     64'(rd[31:0]), 64'h33);
        we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h34;
        step();
        idle();
        #1;
        check_val("sb_wr_clears", 64'(rbusy[0]), 64'h0);
        rsv_en = 1'b1; rsv_addr = 5'd3;
        step();
        rsv_en = 1'b1; rsv_addr = 5'd3; flush = 1'b1;
        step();
        idle();
        #1;
        check_val("sb_flush_busy", 64'(rbusy[0]), 64'h0);
        check_val("sb_flush_conf", 64'(rsv_conflict), 64'h0);

        // Bypass: same-cycle read of the register being written.
        ra = {5'd0, 5'd9};
        we0 = 1'b1; wa0 = 5'd9; wd0 = 32'hA5A5A5A5;
        #1;
`ifdef REG_FILE_SB_BYPASS_EN
        check_val("bypass_same", 64'(rd[31:0]), 64'hA5A5A5A5);
`else
        check_val("bypass_same", 64'(rd[31:0]), 64'h0);
`endif
        step();
        idle();
        #1;
        check_val("bypass_next", 64'(rd[31:0]), 64'hA5A5A5A5);

        // Wide instance: three ports read distinct registers.
        b_we0 = 1'b1; b_wa0 = 4'd1; b_wd0 = 64'h1111_0000_0000_0001;
        b_we1 = 1'b1; b_wa1 = 4'd8; b_wd1 = 64'h8888_0000_0000_0008;
        step();
        idle();
        b_we0 = 1'b1; b_wa0 = 4'd15; b_wd0 = 64'hFFFF_0000_0000_000F;
        step();
        idle();
        b_ra = {4'd15, 4'd8, 4'd1};
        #1;
        check_val("wide_p0", b_rd[63:0],    64'h1111_0000_0000_0001);
        check_val("wide_p1", b_rd[127:64],  64'h8888_0000_0000_0008);
        check_val("wide_p2", b_rd[191:128], 64'hFFFF_0000_0000_000F);
        check_val("wide_rbusy", 64'(b_rbusy), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
